// File: rtl/fabosc_reset_sequencer.sv
// Fabric reset and timebase sequencer on the RC oscillator fabric clock.
// Holds fabric reset until CCC lock and init-done are stable, then runs a tick and heartbeat.
module fabosc_reset_sequencer #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int STRETCH_CYCLES = 1024,
  parameter int HB_TICKS       = 500
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic CCC_LOCK,
  input  logic INIT_DONE,
  output logic FAB_RESET_N,
  output logic READY,
  output logic TICK,
  output logic HEARTBEAT
);

  localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int STR_W = $clog2(STRETCH_CYCLES + 1);
  localparam int DIV_W = $clog2(DIV);
  localparam int HB_W  = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;

  localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_MAX  = STR_W'(STRETCH_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_TICKS - 1);

  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_STRETCH = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [1:0]       lock_sync;
  logic [1:0]       init_sync;
  logic             lock_s;
  logic             init_s;
  logic             ok;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [STR_W-1:0] stretch_cnt;
  logic             run_hold;
  logic             fab_reset_n_q;
  logic [DIV_W-1:0] div_cnt;
  logic             tick_q;
  logic [HB_W-1:0]  hb_cnt;
  logic             hb_q;

  // Two-flop synchronizers; both inputs are asynchronous to CLK.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      lock_sync <= '0;
      init_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[0], CCC_LOCK};
      init_sync <= {init_sync[0], INIT_DONE};
    end
  end

  assign lock_s = lock_sync[1];
  assign init_s = init_sync[1];
  assign ok     = lock_s & init_s;

  // NOTE: next-state starts from a default so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT: begin
        if (ok) state_nxt = ST_STRETCH;
      end
      ST_STRETCH: begin
        if (!ok)                           state_nxt = ST_WAIT;
        else if (stretch_cnt == STR_LAST)  state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!ok) state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= ST_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Saturates rather than wrapping; only a fresh WAIT->STRETCH entry restarts it.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      stretch_cnt <= '0;
    end else if (state == ST_WAIT && ok) begin
      stretch_cnt <= '0;
    end else if (state == ST_STRETCH && ok && stretch_cnt != STR_MAX) begin
      stretch_cnt <= stretch_cnt + STR_W'(1);
    end
  end

  // Fabric reset follows the RUN state on the same edge it is entered or left.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      fab_reset_n_q <= 1'b0;
    end else begin
      fab_reset_n_q <= (state_nxt == ST_RUN);
    end
  end

  // Timebase only advances while RUN is held; losing ok clears it and drops a pending tick.
  assign run_hold = (state == ST_RUN) && ok;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (!run_hold) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q  <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      hb_cnt <= '0;
      hb_q   <= 1'b0;
    end else if (!run_hold) begin
      hb_cnt <= '0;
      hb_q   <= 1'b0;
    end else if (tick_q) begin
      if (hb_cnt == HB_LAST) begin
        hb_cnt <= '0;
        hb_q   <= ~hb_q;
      end else begin
        hb_cnt <= hb_cnt + HB_W'(1);
      end
    end
  end

  assign FAB_RESET_N = fab_reset_n_q;
  assign READY       = fab_reset_n_q;
  assign TICK        = tick_q;
  assign HEARTBEAT   = hb_q;

endmodule
